npu_inst_sequencer: RTL

Fetches 32-bit NPU instructions from a synchronous-read instruction memory, decodes them through instruction_decoder, and issues compute instructions to the execution datapath over a valid/ready handshake. It handles control opcodes (NOP, JUMP, HALT) internally and reports busy, done and an issued-instruction count. It sits between the host start/control interface and the NPU execute unit.

---
 rtl/npu_seq_pkg.sv | 20 ++
 rtl/npu_inst_sequencer_decoder.sv | 14 +
 rtl/npu_inst_sequencer.sv | 110 +++++++++++
 3 files changed

// File: rtl/npu_seq_pkg.sv
// Shared types and constants for the NPU instruction sequencer.
package npu_seq_pkg;
  localparam int INST_W = 32;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JUMP = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    IDLE, FETCH, CAPTURE, EXEC, ISSUE, DONE
  } state_t;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [5:0]  src1;
    logic [5:0]  src2;
    logic [1:0]  dest;
    logic [15:0] imm;
  } dec_t;
endpackage

// File: rtl/npu_inst_sequencer_decoder.sv
// Field extraction for 32-bit NPU instructions.
// Layout: opcode[31:28] src1[27:22] src2[21:16] dest[15:14] imm[15:0] (dest shares imm's top bits).
module instruction_decoder
  import npu_seq_pkg::*;
(
  input  logic [INST_W-1:0] inst,
  output dec_t              dec
);
  assign dec.opcode = inst[31:28];
  assign dec.src1   = inst[27:22];
  assign dec.src2   = inst[21:16];
  assign dec.dest   = inst[15:14];
  assign dec.imm    = inst[15:0];
endmodule

// File: rtl/npu_inst_sequencer.sv
// Fetch/decode/issue sequencer: one instruction in flight, control opcodes handled locally.
module npu_inst_sequencer
  import npu_seq_pkg::*;
#(
  parameter int IMEM_AW = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [IMEM_AW-1:0] start_pc,
  input  logic               abort,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [INST_W-1:0]  imem_rdata,
  output logic               issue_valid,
  input  logic               issue_ready,
  output logic [3:0]         issue_opcode,
  output logic [5:0]         issue_src1,
  output logic [5:0]         issue_src2,
  output logic [1:0]         issue_dest,
  output logic [15:0]        issue_imm,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   issued_count,
  output logic [IMEM_AW-1:0] pc_out
);
  state_t             state_q, state_d;
  logic [IMEM_AW-1:0] pc_q, pc_d;
  logic [INST_W-1:0]  inst_q, inst_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  dec_t               dec;

  instruction_decoder u_dec (.inst(inst_q), .dec(dec));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      inst_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (start) begin
        pc_d    = start_pc;
        cnt_d   = '0;
        state_d = FETCH;
      end
      FETCH:   state_d = CAPTURE;
      CAPTURE: begin
        inst_d  = imem_rdata;
        state_d = EXEC;
      end
      EXEC: begin
        unique case (dec.opcode)
          OP_NOP: begin
            pc_d    = pc_q + IMEM_AW'(1);
            state_d = FETCH;
          end
          OP_JUMP: begin
            pc_d    = dec.imm[IMEM_AW-1:0];
            state_d = FETCH;
          end
          OP_HALT: state_d = DONE;
          default: state_d = ISSUE;
        endcase
      end
      ISSUE: if (issue_ready) begin
        pc_d    = pc_q + IMEM_AW'(1);
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = FETCH;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // abort outranks start, handshakes and control flow; architectural state is kept
    if (abort) begin
      state_d = IDLE;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      inst_d  = inst_q;
    end
  end

  // Outputs decode straight from the state register so reset clears them without a clock.
  assign imem_en      = (state_q == FETCH);
  assign imem_addr    = pc_q;
  assign issue_valid  = (state_q == ISSUE);
  assign issue_opcode = dec.opcode;
  assign issue_src1   = dec.src1;
  assign issue_src2   = dec.src2;
  assign issue_dest   = dec.dest;
  assign issue_imm    = dec.imm;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign issued_count = cnt_q;
  assign pc_out       = pc_q;
endmodule
